// File: rtl/iiitb_gc.sv
// iiitb_gc: synchronous Gray-code counter.
// A binary count register is advanced on enabled edges and its Gray image
// is loaded into a separate output register on the same edge.
// The output therefore comes straight from flops, and it never lags the binary count.

// One Gray output bit. It is the XOR of a binary bit and the bit above it.
module iiitb_gc_bit (
    input  logic b_hi,
    input  logic b_lo,
    output logic g
);
    // Gray bit i = bin[i+1] ^ bin[i]; the top bit sees a constant 0 above it
    always_comb g = b_hi ^ b_lo;
endmodule

module iiitb_gc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             enable,
    input  logic             reset,
    output logic [WIDTH-1:0] gray_count
);
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH:0]   bin_ext;
    logic [WIDTH-1:0] gray_next;

    // Next binary value; it wraps naturally modulo 2^WIDTH
    always_comb begin
        bin_next = bin + WIDTH'(1);
        bin_ext  = {1'b0, bin_next};
    end

    // The Gray image of the next count is built one bit per cell
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        iiitb_gc_bit u_bit (
            .b_hi (bin_ext[i+1]),
            .b_lo (bin_ext[i]),
            .g    (gray_next[i])
        );
    end

    // Both registers move together, so gray_count == bin ^ (bin >> 1) after every edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            bin        <= '0;
            gray_count <= '0;
        end else if (enable) begin
            bin        <= bin_next;
            gray_count <= gray_next;
        end
    end
endmodule

// File: tb/tb_iiitb_gc.sv
// Randomized scoreboard bench for iiitb_gc.
// The driver pushes the expected code for each edge.
// The monitor pops that entry after the edge and compares it with the output.
module tb_iiitb_gc;
    logic       clk = 1'b0;
    logic       enable = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] gray_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] exp;
        bit         rst;
        bit         en;
    } exp_t;

    exp_t q[$];
    int   n_en = 0;

    iiitb_gc #(.WIDTH(8)) dut (
        .clk        (clk),
        .enable     (enable),
        .reset      (reset),
        .gray_count (gray_count)
    );

    always #5 clk = ~clk;

    // Reference: the Gray code of the number of enabled edges since reset
    function automatic logic [7:0] gray_of(input int n);
        int m;
        m = n % 256;
        return 8'(m ^ (m / 2));
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    // Drive the inputs midway between edges, then record the expected result of the coming edge
    task automatic step(input bit rst_n, input bit en);
        exp_t e;
        @(negedge clk);
        reset  = rst_n;
        enable = en;
        if (!rst_n) n_en = 0;
        else if (en) n_en++;
        e.exp = gray_of(n_en);
        e.rst = !rst_n;
        e.en  = en;
        q.push_back(e);
    endtask

    // Monitor: after each rising edge, compare against the oldest expectation and check the bit-change count
    logic [7:0] prev = 8'h00;
    always @(posedge clk) begin
        exp_t e;
        int   d;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("scoreboard", gray_count, e.exp);
            if (!e.rst) begin
                d = $countones(prev ^ gray_count);
                total++;
                if (d != (e.en ? 1 : 0)) begin
                    bad++;
                    $display("FAIL bitdelta: %0d bits changed (%02h->%02h) expected %0d",
                             d, prev, gray_count, e.en ? 1 : 0);
                end
            end
            prev = gray_count;
        end
    end

    logic [7:0] seq_tbl [8] = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C};

    initial begin
        // Reset held for two edges while enable is high
        step(0, 1);
        step(0, 1);
        @(posedge clk); #2;
        chk("reset_val", gray_count, 8'h00);
        // Check the start of the sequence against literal values
        for (int i = 0; i < 8; i++) begin
            step(1, 1);
            @(posedge clk); #2;
            chk("seq", gray_count, seq_tbl[i]);
        end

        // Enable hold at 0x06
        step(0, 0);
        for (int i = 0; i < 4; i++) step(1, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            @(posedge clk); #2;
            chk("hold", gray_count, 8'h06);
        end
        step(1, 1);
        @(posedge clk); #2;
        chk("hold_resume", gray_count, 8'h07);

        // Wrap at 255 -> 0
        step(0, 1);
        for (int i = 0; i < 255; i++) step(1, 1);
        @(posedge clk); #2;
        chk("wrap_80", gray_count, 8'h80);
        step(1, 1);
        @(posedge clk); #2;
        chk("wrap_00", gray_count, 8'h00);
        step(1, 1);
        @(posedge clk); #2;
        chk("wrap_01", gray_count, 8'h01);

        // Reset asserted between edges while counting
        step(0, 1);
        for (int i = 0; i < 37; i++) step(1, 1);
        @(posedge clk); #2;
        chk("pre_midreset", gray_count, 8'h37);
        step(0, 1);
        #2;
        chk("midreset_wait", gray_count, 8'h37);
        @(posedge clk); #2;
        chk("midreset_edge", gray_count, 8'h00);
        step(1, 1);
        @(posedge clk); #2;
        chk("midreset_next", gray_count, 8'h01);

        // Long run through three wraps
        step(0, 0);
        for (int i = 0; i < 1000; i++) step(1, 1);

        // Random enable pattern
        for (int i = 0; i < 2000; i++) step(1, 1'($urandom_range(0, 1)));

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
